// File: rtl/prio_event_encoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : prio_event_encoder                                       |
// | Description : Registered N-line priority event encoder. Requests are   |
// |               captured into a pending register, gated by an enable     |
// |               mask, and one winner index is presented on a valid/ready |
// |               handshake. Selection is fixed priority (highest index)   |
// |               or round-robin. A sticky overflow flag reports requests  |
// |               that hit an already-pending bit.                         |
// | Ports       : clk        rising-edge clock                             |
// |               rst_n      asynchronous active-low reset                 |
// |               req[N]     request lines, sampled every cycle            |
// |               mask[N]    1 = line eligible for selection               |
// |               out_ready  consumer accepts the presented index          |
// |               clr_ovf    clears the overflow flag                      |
// |               out_idx[W] presented index (held while out_valid = 0)    |
// |               out_valid  out_idx is valid                              |
// |               pending[N] pending request register                      |
// |               overflow   sticky lost-request flag                      |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module prio_event_encoder #(
    parameter int N           = 8,
    parameter int W           = $clog2(N),
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         out_ready,
    input  logic         clr_ovf,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    output logic [N-1:0] pending,
    output logic         overflow
);

    localparam logic [0:0]   c_ST_IDLE    = 1'b0;
    localparam logic [0:0]   c_ST_PRESENT = 1'b1;
    // After reset the pointer sits on N-1 so the RR search starts at N-2.
    localparam logic [W-1:0] c_LAST_RST   = W'(N - 1);
    localparam logic [N-1:0] c_ONE        = {{(N-1){1'b0}}, 1'b1};

    logic [0:0]   r_state;
    logic [0:0]   w_state_nxt;
    logic [N-1:0] r_pending;
    logic [W-1:0] r_idx;
    logic [W-1:0] r_last;
    logic         r_ovf;

    logic         w_valid;
    logic         w_accept;
    logic         w_load;
    logic [N-1:0] w_clr_vec;
    logic [N-1:0] w_elig;
    logic [N-1:0] w_pending_nxt;
    logic         w_ovf_nxt;
    logic [W-1:0] w_winner;

    assign out_idx   = r_idx;
    assign out_valid = w_valid;
    assign pending   = r_pending;
    assign overflow  = r_ovf;

    // Eligibility uses the registered pending value: a request arriving
    // this cycle only competes from the next cycle on.
    assign w_elig        = r_pending & mask;
    assign w_clr_vec     = w_accept ? (c_ONE << r_idx) : '0;
    // Set wins over clear for a bit re-requested in its accept cycle.
    assign w_pending_nxt = (r_pending & ~w_clr_vec) | req;
    // A new overflow event takes precedence over clr_ovf.
    assign w_ovf_nxt     = (|(req & r_pending & ~w_clr_vec)) | (r_ovf & ~clr_ovf);

    // Winner selection. Iterating from lowest to highest priority and letting
    // later hits overwrite earlier ones leaves the top-priority hit in place.
    always_comb begin
        int k;
        k        = 0;
        w_winner = '0;
        if (ROUND_ROBIN) begin
            // Priority order: last-1 (highest), last-2, ..., wrapping, last (lowest).
            for (int s = N; s >= 1; s--) begin
                k = (int'(r_last) + N - s) % N;
                if (w_elig[k]) w_winner = k[W-1:0];
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_elig[i]) w_winner = i[W-1:0];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:    if (|w_elig)   w_state_nxt = c_ST_PRESENT;
            c_ST_PRESENT: if (out_ready) w_state_nxt = c_ST_IDLE;
            default:                     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // FSM: outputs and datapath controls
    always_comb begin
        w_valid  = (r_state == c_ST_PRESENT);
        w_accept = w_valid & out_ready;
        w_load   = (r_state == c_ST_IDLE) & (|w_elig);
    end

    // Datapath registers. out_idx only loads on entry to PRESENT, so a mask
    // change while presenting cannot retract or alter the presented index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_idx     <= '0;
            r_ovf     <= 1'b0;
            r_last    <= c_LAST_RST;
        end else begin
            r_pending <= w_pending_nxt;
            r_ovf     <= w_ovf_nxt;
            if (w_load) begin
                r_idx <= w_winner;
            end
            if (ROUND_ROBIN && w_accept) begin
                r_last <= r_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prio_event_encoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_prio_event_encoder                                    |
// | Description : Self-checking bench for prio_event_encoder (N = 8).      |
// |               A fixed-priority and a round-robin instance share the    |
// |               same stimulus; both are compared every cycle against a   |
// |               behavioural model, plus directed scenario checks.        |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_prio_event_encoder;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic         out_ready;
    logic         clr_ovf;

    logic [W-1:0] f_idx, r_idx;
    logic         f_valid, r_valid;
    logic [N-1:0] f_pend, r_pend;
    logic         f_ovf, r_ovf;

    int errors = 0;
    int checks = 0;

    // Model state, index 0 = fixed priority, 1 = round-robin
    logic [N-1:0] m_pend[2];
    bit           m_valid[2];
    int           m_idx[2];
    bit           m_ovf[2];
    int           m_last[2];

    int rr_order[8] = '{6, 5, 4, 3, 2, 1, 0, 7};

    always #5 clk = ~clk;

    prio_event_encoder #(.N(N), .ROUND_ROBIN(1'b0)) u_fix (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask),
        .out_ready(out_ready), .clr_ovf(clr_ovf),
        .out_idx(f_idx), .out_valid(f_valid), .pending(f_pend), .overflow(f_ovf)
    );

    prio_event_encoder #(.N(N), .ROUND_ROBIN(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask),
        .out_ready(out_ready), .clr_ovf(clr_ovf),
        .out_idx(r_idx), .out_valid(r_valid), .pending(r_pend), .overflow(r_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner per the selection rules: highest index, or first hit searching
    // downward from last-1 with wrap-around.
    function automatic int pick(input logic [N-1:0] e, input int mode, input int last);
        if (mode == 0) begin
            for (int k = N - 1; k >= 0; k--) if (e[k]) return k;
        end else begin
            for (int s = 1; s <= N; s++) begin
                int k = (last - s + N) % N;
                if (e[k]) return k;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m]  = '0;
            m_valid[m] = 0;
            m_idx[m]   = 0;
            m_ovf[m]   = 0;
            m_last[m]  = N - 1;
        end
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] mk,
                              input logic rdy, input logic co);
        for (int m = 0; m < 2; m++) begin
            bit           acc;
            logic [N-1:0] clr, elig;
            bit           set;
            acc  = m_valid[m] && rdy;
            clr  = acc ? N'(1 << m_idx[m]) : '0;
            elig = m_pend[m] & mk;
            set  = |(r & m_pend[m] & ~clr);
            m_pend[m] = (m_pend[m] & ~clr) | r;
            if (set)     m_ovf[m] = 1;
            else if (co) m_ovf[m] = 0;
            if (m_valid[m]) begin
                if (acc) begin
                    m_valid[m] = 0;
                    if (m == 1) m_last[m] = m_idx[m];
                end
            end else if (elig != 0) begin
                m_idx[m]   = pick(elig, m, m_last[m]);
                m_valid[m] = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("fix_valid", f_valid, m_valid[0]);
        chk("fix_idx",   f_idx,   m_idx[0]);
        chk("fix_pend",  f_pend,  m_pend[0]);
        chk("fix_ovf",   f_ovf,   m_ovf[0]);
        chk("rr_valid",  r_valid, m_valid[1]);
        chk("rr_idx",    r_idx,   m_idx[1]);
        chk("rr_pend",   r_pend,  m_pend[1]);
        chk("rr_ovf",    r_ovf,   m_ovf[1]);
    endtask

    // Drive inputs away from the clock edge, advance the model, sample #1 after the edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] mk,
                        input logic rdy, input logic co);
        req = r; mask = mk; out_ready = rdy; clr_ovf = co;
        model_step(r, mk, rdy, co);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; req = '0; mask = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_fix_valid", f_valid, 0);
        chk("rst_rr_pend",   r_pend,  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fixed: 0010_0100 -> 5 then 2
        step(8'h24, 8'hFF, 1'b1, 1'b0);
        step(8'h00, 8'hFF, 1'b1, 1'b0);
        chk("t1_fix_first", {f_valid, f_idx}, {1'b1, 3'd5});
        chk("t1_rr_first",  {r_valid, r_idx}, {1'b1, 3'd5});
        step(8'h00, 8'hFF, 1'b1, 1'b0);
        step(8'h00, 8'hFF, 1'b1, 1'b0);
        chk("t1_fix_second", {f_valid, f_idx}, {1'b1, 3'd2});
        step(8'h00, 8'hFF, 1'b1, 1'b0);
        chk("t1_fix_pend_empty", f_pend, 8'h00);
        chk("t1_fix_no_ovf", f_ovf, 0);

        // Back-pressure: idx 7 held for 5 cycles with mask dropped to 0
        step(8'h80, 8'hFF, 1'b0, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(8'h00, 8'h00, 1'b0, 1'b0);
            chk("t2_fix_hold", {f_valid, f_idx}, {1'b1, 3'd7});
            chk("t2_rr_hold",  {r_valid, r_idx}, {1'b1, 3'd7});
        end
        step(8'h00, 8'h00, 1'b1, 1'b0);
        chk("t2_accept_valid", f_valid, 0);
        chk("t2_accept_pend",  f_pend, 8'h00);

        // Overflow: req[3] twice before the grant
        step(8'h08, 8'hFF, 1'b0, 1'b0);
        step(8'h08, 8'hFF, 1'b0, 1'b0);
        chk("t3_fix_ovf_set", f_ovf, 1);
        chk("t3_rr_ovf_set",  r_ovf, 1);
        chk("t3_fix_idx", {f_valid, f_idx}, {1'b1, 3'd3});
        step(8'h00, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 8'hFF, 1'b1, 1'b0);
            chk("t3_single_grant", f_valid, 0);
        end
        step(8'h00, 8'hFF, 1'b0, 1'b1);
        chk("t3_fix_ovf_clr", f_ovf, 0);
        chk("t3_rr_ovf_clr",  r_ovf, 0);

        // Set wins: req[4] in the accept cycle of idx 4
        step(8'h10, 8'hFF, 1'b0, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        chk("t4_rr_first", {r_valid, r_idx}, {1'b1, 3'd4});
        step(8'h10, 8'hFF, 1'b1, 1'b0);
        chk("t4_pend_kept", f_pend, 8'h10);
        chk("t4_no_ovf", f_ovf, 0);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        chk("t4_fix_regrant", {f_valid, f_idx}, {1'b1, 3'd4});
        chk("t4_rr_regrant",  {r_valid, r_idx}, {1'b1, 3'd4});
        step(8'h00, 8'hFF, 1'b1, 1'b0);

        // Reset mid-handshake with pending = 0x81
        step(8'h81, 8'hFF, 1'b0, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        chk("t5_pre_valid", f_valid, 1);
        chk("t5_pre_pend",  f_pend, 8'h81);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_fix_async", {f_valid, f_idx, f_pend, f_ovf}, '0);
        chk("t5_rr_async",  {r_valid, r_idx, r_pend, r_ovf}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 8'hFF, 1'b1, 1'b0);
            chk("t5_no_grant", {f_valid, r_valid}, 2'b00);
        end

        // RR order from reset: 6,5,4,3,2,1,0,7 ; fixed gives 7..0
        step(8'hFF, 8'hFF, 1'b1, 1'b0);
        for (int g = 0; g < 8; g++) begin
            step(8'h00, 8'hFF, 1'b1, 1'b0);
            chk("t6_rr_order",  {r_valid, r_idx}, {1'b1, 3'(rr_order[g])});
            chk("t6_fix_order", {f_valid, f_idx}, {1'b1, 3'(7 - g)});
            step(8'h00, 8'hFF, 1'b1, 1'b0);
        end
        chk("t6_rr_drained", r_pend, 8'h00);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] r, mk;
            r  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            mk = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            step(r, mk, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
